// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM copy controller: FSM state encoding,
// address step per word and per-byte-lane write-enable values.
package bram_pkg;

  // Copy controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Byte-address increment between consecutive words
  localparam int BYTES_PER_WORD = 4;

  // Per-byte-lane write enable values; replicated to the full WE width
  localparam logic WE_ALL  = 1'b1;
  localparam logic WE_NONE = 1'b0;

endpackage

// File: rtl/bram_addr_ctr.sv
// Loadable word-address counter: loads a byte base address, then advances by
// one word per step. Arithmetic wraps naturally modulo 2^ADDR_WIDTH.
module bram_addr_ctr
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTES_PER_WORD);

  logic [ADDR_WIDTH-1:0] addr_reg;

  // Load has priority over step so a new transfer always starts at its base
  always_ff @(posedge clk) begin
    if (srst) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= base;
    end else if (step) begin
      addr_reg <= addr_reg + STEP;
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/bram_copy_ctrl.sv
// BRAM-to-BRAM word copy controller. One read per cycle from the source port,
// the returned word is written to the destination port the following cycle.
// Optional feature: define BRAM_COPY_CHECKSUM_EN to add a running
// modulo-2^DATA_WIDTH sum of all written words on the checksum output.
module bram_copy_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    BRAM_CLK,
  input  logic                    BRAM_RST,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_base,
  input  logic [ADDR_WIDTH-1:0]   dst_base,
  input  logic [ADDR_WIDTH-2:0]   len_words,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   SRC_ADDR,
  output logic                    SRC_EN,
  output logic [DATA_WIDTH/8-1:0] SRC_WE,
  input  logic [DATA_WIDTH-1:0]   SRC_RDDATA,
  output logic [ADDR_WIDTH-1:0]   DST_ADDR,
  output logic                    DST_EN,
  output logic [DATA_WIDTH/8-1:0] DST_WE,
  output logic [DATA_WIDTH-1:0]   DST_WRDATA
`ifdef BRAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]   checksum
`endif
);

  localparam int WE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-2:0] LEN_ONE = (ADDR_WIDTH-1)'(1);

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-2:0] remain_reg;
  logic                  wr_pend_reg;
  logic                  accept;
  logic                  rd_issue;

  // Next-state logic; a start outside IDLE is simply dropped
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (len_words == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (remain_reg == LEN_ONE) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign rd_issue = (state_reg == ST_RUN);

  // Words still to be read; reaching one in RUN means the final issue is now
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      remain_reg <= '0;
    end else if (accept) begin
      remain_reg <= len_words;
    end else if (rd_issue) begin
      remain_reg <= remain_reg - LEN_ONE;
    end
  end

  // A write is owed the cycle after every read issue; reset drops it
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      wr_pend_reg <= 1'b0;
    end else begin
      wr_pend_reg <= rd_issue;
    end
  end

  bram_addr_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_src_ctr (
    .clk  (BRAM_CLK),
    .srst (BRAM_RST),
    .load (accept),
    .base (src_base),
    .step (rd_issue),
    .addr (SRC_ADDR)
  );

  bram_addr_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dst_ctr (
    .clk  (BRAM_CLK),
    .srst (BRAM_RST),
    .load (accept),
    .base (dst_base),
    .step (wr_pend_reg),
    .addr (DST_ADDR)
  );

  assign busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done       = (state_reg == ST_DONE);
  assign SRC_EN     = rd_issue;
  assign DST_EN     = wr_pend_reg;
  assign DST_WRDATA = SRC_RDDATA;

  // Byte-lane enables: source port never writes, destination writes whole words
  genvar gi;
  generate
    for (gi = 0; gi < WE_W; gi++) begin : g_we
      assign SRC_WE[gi] = WE_NONE;
      assign DST_WE[gi] = wr_pend_reg ? WE_ALL : WE_NONE;
    end
  endgenerate

`ifdef BRAM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_reg;

  // Running sum of written words; cleared by reset or any accepted start
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST || accept) begin
      checksum_reg <= '0;
    end else if (wr_pend_reg) begin
      checksum_reg <= checksum_reg + SRC_RDDATA;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// Self-checking bench for bram_copy_ctrl: two behavioural BRAMs, a timeline
// model of each copy (read k at offset k, write k at offset k+1, done after
// the last write), a per-cycle compare and directed literal checks.
`timescale 1ns/1ps
module tb_bram_copy_ctrl;

  localparam int AW     = 15;
  localparam int DW     = 32;
  localparam int WEW    = DW / 8;
  localparam int NWORDS = 1 << (AW - 2);

  logic            BRAM_CLK = 1'b0;
  logic            BRAM_RST = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   src_base = '0;
  logic [AW-1:0]   dst_base = '0;
  logic [AW-2:0]   len_words = '0;
  logic            busy, done, SRC_EN, DST_EN;
  logic [AW-1:0]   SRC_ADDR, DST_ADDR;
  logic [WEW-1:0]  SRC_WE, DST_WE;
  logic [DW-1:0]   SRC_RDDATA, DST_WRDATA;
`ifdef BRAM_COPY_CHECKSUM_EN
  logic [DW-1:0]   checksum;
`endif

  bram_copy_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .BRAM_CLK   (BRAM_CLK),
    .BRAM_RST   (BRAM_RST),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .SRC_ADDR   (SRC_ADDR),
    .SRC_EN     (SRC_EN),
    .SRC_WE     (SRC_WE),
    .SRC_RDDATA (SRC_RDDATA),
    .DST_ADDR   (DST_ADDR),
    .DST_EN     (DST_EN),
    .DST_WE     (DST_WE),
    .DST_WRDATA (DST_WRDATA)
`ifdef BRAM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 BRAM_CLK = ~BRAM_CLK;

  // Behavioural memories plus the image the destination should end up holding
  logic [DW-1:0] src_mem [NWORDS];
  logic [DW-1:0] dst_mem [NWORDS];
  logic [DW-1:0] exp_dst [NWORDS];
  logic [WEW-1:0] we_all = '1;

  int total = 0;
  int bad   = 0;

  // Model state: per = edges seen, acc = edge index of the accepted start
  int            per = 0;
  int            acc = 0;
  bit            active = 0;
  bit            after_rst = 0;
  bit            seen_rst = 0;
  int            m_len = 0;
  logic [AW-1:0] m_src = '0;
  logic [AW-1:0] m_dst = '0;
  logic [DW-1:0] exp_csum = '0;

  // Observations gathered by the compare process for directed checks
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            busy_cnt = 0;
  int            done_per = -1;
  logic [AW-1:0] src_log[$];
  logic [AW-1:0] dst_log[$];

  function automatic int done_d(input int l);
    return (l == 0) ? 0 : l + 1;
  endfunction

  function automatic logic [AW-1:0] addr_k(input logic [AW-1:0] b, input int k);
    return b + AW'(4 * k);
  endfunction

  function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
    return src_mem[a[AW-1:2]];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The two BRAMs: registered source read, destination write on full WE
  always @(posedge BRAM_CLK) begin
    if (SRC_EN) SRC_RDDATA <= src_mem[SRC_ADDR[AW-1:2]];
    if (DST_EN && DST_WE == we_all) dst_mem[DST_ADDR[AW-1:2]] <= DST_WRDATA;
  end

  // Reference model: advance one cycle of the copy timeline per edge
  always @(posedge BRAM_CLK) begin
    int d;
    logic [AW-1:0] wa;
    d = per - acc;
    if (active && d >= 1 && d <= m_len) begin
      wa = addr_k(m_dst, d - 1);
      exp_dst[wa[AW-1:2]] = src_word(addr_k(m_src, d - 1));
      exp_csum = exp_csum + src_word(addr_k(m_src, d - 1));
    end
    per = per + 1;
    if (BRAM_RST) begin
      active    = 0;
      after_rst = 1;
      seen_rst  = 1;
      exp_csum  = '0;
    end else if (seen_rst && start && (!active || d > done_d(m_len))) begin
      active    = 1;
      acc       = per;
      m_len     = int'(len_words);
      m_src     = src_base;
      m_dst     = dst_base;
      after_rst = 0;
      exp_csum  = '0;
    end
  end

  // Per-cycle compare of every DUT output against the model timeline
  always @(negedge BRAM_CLK) begin
    int d;
    bit e_sen, e_den, e_busy, e_done;
    if (seen_rst) begin
      d      = per - acc;
      e_sen  = active && d >= 0 && d < m_len;
      e_den  = active && d >= 1 && d <= m_len;
      e_busy = active && m_len > 0 && d >= 0 && d <= m_len;
      e_done = active && d == done_d(m_len);
      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_done));
      check("src_en", 64'(SRC_EN), 64'(e_sen));
      check("dst_en", 64'(DST_EN), 64'(e_den));
      check("dst_we", 64'(DST_WE), e_den ? 64'(we_all) : 64'(0));
      check("src_we", 64'(SRC_WE), 64'(0));
      if (e_sen) check("src_addr", 64'(SRC_ADDR), 64'(addr_k(m_src, d)));
      if (e_den) begin
        check("dst_addr", 64'(DST_ADDR), 64'(addr_k(m_dst, d - 1)));
        check("dst_data", 64'(DST_WRDATA), 64'(src_word(addr_k(m_src, d - 1))));
      end
      if (after_rst) begin
        check("rst_src_addr", 64'(SRC_ADDR), 64'(0));
        check("rst_dst_addr", 64'(DST_ADDR), 64'(0));
      end
`ifdef BRAM_COPY_CHECKSUM_EN
      check("checksum", 64'(checksum), 64'(exp_csum));
`endif
      if (DST_EN) begin
        wr_cnt++;
        dst_log.push_back(DST_ADDR);
      end
      if (SRC_EN) src_log.push_back(SRC_ADDR);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_per = per;
      end
    end
  end

  task automatic clear_obs();
    wr_cnt = 0;
    done_cnt = 0;
    busy_cnt = 0;
    done_per = -1;
    src_log.delete();
    dst_log.delete();
  endtask

  // One copy: start pulse, bounded wait for done, optional stray start mid-run
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int l, input bit poke);
    bit got;
    @(negedge BRAM_CLK);
    clear_obs();
    src_base  = s;
    dst_base  = d;
    len_words = (AW-1)'(l);
    start     = 1'b1;
    got = 0;
    for (int n = 0; n < l + 8 && !got; n++) begin
      @(negedge BRAM_CLK);
      start = 1'b0;
      if (n == 0) begin
        src_base  = AW'($urandom);
        dst_base  = AW'($urandom);
        len_words = (AW-1)'($urandom);
      end
      if (done) got = 1;
      else if (poke && n == 2) start = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'(1));
    repeat (3) @(negedge BRAM_CLK);
    check("one_done", 64'(done_cnt), 64'(1));
    check("done_ofs", 64'(done_per - acc), 64'(done_d(l)));
    check("wr_count", 64'(wr_cnt), 64'(l));
    $display("copy src=%h dst=%h len=%0d poke=%0d done_ofs=%0d writes=%0d",
             s, d, l, poke, done_per - acc, wr_cnt);
  endtask

  task automatic check_image(input string name);
    int nb;
    nb = 0;
    for (int i = 0; i < NWORDS; i++) if (dst_mem[i] !== exp_dst[i]) nb++;
    check(name, 64'(nb), 64'(0));
  endtask

  initial begin
    int nb;
    for (int i = 0; i < NWORDS; i++) begin
      src_mem[i] = $urandom;
      dst_mem[i] = '0;
      exp_dst[i] = '0;
    end
    BRAM_RST = 1'b1;
    repeat (3) @(negedge BRAM_CLK);
    BRAM_RST = 1'b0;
    @(negedge BRAM_CLK);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_src_addr", 64'(SRC_ADDR), 64'(0));

    // Long copy of an identity pattern
    for (int i = 0; i < 2048; i++) src_mem[i] = DW'(i);
    run_copy(AW'(0), AW'(0), 2048, 0);
    check("big_done_ofs", 64'(done_per - acc), 64'(2049));
    check("big_busy_cycles", 64'(busy_cnt), 64'(2049));
    nb = 0;
    for (int i = 0; i < 2048; i++) if (dst_mem[i] !== DW'(i)) nb++;
    check("big_identity", 64'(nb), 64'(0));
    check_image("big_image");

    // Zero length: immediate done, no access
    run_copy(AW'(16'h0040), AW'(16'h0080), 0, 0);
    check("zero_done_ofs", 64'(done_per - acc), 64'(0));
    check("zero_reads", 64'(src_log.size()), 64'(0));
    check("zero_writes", 64'(dst_log.size()), 64'(0));

    // Address wrap at the top of the space
    run_copy(AW'(16'h7FFC), AW'(16'h7FFC), 3, 0);
    check("wrap_nrd", 64'(src_log.size()), 64'(3));
    check("wrap_nwr", 64'(dst_log.size()), 64'(3));
    if (src_log.size() == 3 && dst_log.size() == 3) begin
      check("wrap_rd0", 64'(src_log[0]), 64'(16'h7FFC));
      check("wrap_rd1", 64'(src_log[1]), 64'(16'h0000));
      check("wrap_rd2", 64'(src_log[2]), 64'(16'h0004));
      check("wrap_wr0", 64'(dst_log[0]), 64'(16'h7FFC));
      check("wrap_wr1", 64'(dst_log[1]), 64'(16'h0000));
      check("wrap_wr2", 64'(dst_log[2]), 64'(16'h0004));
    end
    check_image("wrap_image");

    // Reset during the 10th RUN cycle of a 100-word copy
    @(negedge BRAM_CLK);
    clear_obs();
    src_base  = AW'(16'h1000);
    dst_base  = AW'(16'h2000);
    len_words = (AW-1)'(100);
    start     = 1'b1;
    @(negedge BRAM_CLK);
    start = 1'b0;
    repeat (9) @(negedge BRAM_CLK);
    BRAM_RST = 1'b1;
    @(negedge BRAM_CLK);
    BRAM_RST = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge BRAM_CLK);
    check("abort_writes", 64'(wr_cnt), 64'(9));
    check("abort_done", 64'(done_cnt), 64'(0));
    $display("abort src=1000 dst=2000 len=100 writes=%0d dones=%0d", wr_cnt, done_cnt);
    check_image("abort_image");
    run_copy(AW'(16'h1000), AW'(16'h2000), 100, 0);
    check_image("after_abort_image");

    // Stray start while running
    run_copy(AW'(16'h3000), AW'(16'h4000), 20, 1);
    check_image("poke_image");

`ifdef BRAM_COPY_CHECKSUM_EN
    for (int i = 0; i < 4; i++) src_mem[(16'h0100 >> 2) + i] = DW'(i + 1);
    run_copy(AW'(16'h0100), AW'(16'h0200), 4, 0);
    check("checksum_1to4", 64'(checksum), 64'(10));
`endif

    // Randomized copies
    for (int t = 0; t < 25; t++) begin
      logic [AW-1:0] s, dd;
      int l;
      s  = AW'($urandom) & ~AW'(3);
      dd = AW'($urandom) & ~AW'(3);
      l  = $urandom_range(0, 40);
      run_copy(s, dd, l, ($urandom_range(0, 1) == 1));
      check_image("rand_image");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_copy_ctrl.md
BRAM_COPY_CTRL -- requirements
Module: bram_copy_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning BRAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning BRAM word width; WE width is DATA_WIDTH/8.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have ports:
- BRAM_CLK  in  1  clock.
- BRAM_RST  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_base  in  ADDR_WIDTH  source byte address, word aligned.
- dst_base  in  ADDR_WIDTH  destination byte address, word aligned.
- len_words  in  ADDR_WIDTH-1  number of words to copy.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at completion.
- SRC_ADDR  out  ADDR_WIDTH  source read address.
- SRC_EN  out  1  source enable.
- SRC_WE  out  DATA_WIDTH/8  constant 0.
- SRC_RDDATA  in  DATA_WIDTH  source read data, valid one cycle after the address.
- DST_ADDR  out  ADDR_WIDTH  destination write address.
- DST_EN  out  1  destination enable.
- DST_WE  out  DATA_WIDTH/8  all-ones when writing, else 0.
- DST_WRDATA  out  DATA_WIDTH  write data.

Function
REQ-005 SHALL implement the FSM IDLE, RUN, DRAIN and DONE.
REQ-006 IDLE with start=1 and len_words>0 SHALL latch the base addresses and length and go to RUN; with start=1 and len_words=0 it SHALL go to DONE with no BRAM access.
REQ-007 RUN SHALL assert SRC_EN=1 each cycle, with SRC_ADDR = src_base + 4*k for k = 0..len-1; after the final issue it SHALL go to DRAIN.
REQ-008 The cycle after each read issue, DST_EN=1, DST_WE=all-ones, DST_ADDR = dst_base + 4*k and DST_WRDATA = SRC_RDDATA (combinational pass-through).
REQ-009 DRAIN SHALL perform the final write and then go to DONE; DONE SHALL pulse done for one cycle and then go to IDLE.
REQ-010 Throughput SHALL be 1 word per cycle; for a start at edge t, the first read is in cycle t+1, the last write in cycle t+len+1 and done in cycle t+len+2.
REQ-011 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH, with no error on overflow.
REQ-012 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-013 Source and destination ranges may overlap; copy order is ascending and no hazard protection is provided.
REQ-014 SRC_EN and DST_EN SHALL be 0, and DST_WE 0, whenever no access is issued.

Reset
REQ-015 BRAM_RST=1 SHALL force IDLE at the next edge, with busy=0, done=0, SRC_EN=0, DST_EN=0, DST_WE=0, SRC_ADDR=0 and DST_ADDR=0.
REQ-016 Reset mid-transfer SHALL abort it immediately: no further writes and no done pulse.

Configuration
REQ-017 Macro BRAM_COPY_CHECKSUM_EN, when defined, SHALL add output checksum [DATA_WIDTH], the modulo-2^DATA_WIDTH sum of all words written.
REQ-018 With BRAM_COPY_CHECKSUM_EN, checksum SHALL clear on accepted start and on reset, and be stable from the done pulse until the next start.
REQ-019 Without BRAM_COPY_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-020 Shared package bram_pkg SHALL hold the FSM state typedef, BYTES_PER_WORD=4 and the WE_ALL/WE_NONE constants.
REQ-021 A single sub-module bram_addr_ctr (loadable base, +4 step, wrap) SHALL be instantiated twice: once for the source and once for the destination.

Verification
REQ-022 src_base=0, dst_base=0, len=2048, source preloaded with word i = i -> destination word i = i, done at cycle t+2050, busy high for 2049 cycles.
REQ-023 len=0 -> done pulse at t+1, SRC_EN and DST_EN never asserted.
REQ-024 src_base=0x7FFC, len=3 -> reads at 0x7FFC, 0x0000, 0x0004; writes wrap identically.
REQ-025 BRAM_RST asserted in the 10th RUN cycle of a len=100 copy -> exactly 9 writes, no done, IDLE next cycle, second start copies correctly.
REQ-026 start pulsed again during RUN -> ignored; exactly one done pulse.
REQ-027 BRAM_COPY_CHECKSUM_EN defined, words 1..4 copied -> checksum=10 at done.
